tmds_decoder: RTL and testbench



---
 rtl/tmds_decoder.sv | 171 +++++++++++++++++
 tb/tb_tmds_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS receive decoder for one DVI channel.
// Registers the deserialized symbol, decodes it to pixel data or control
// bits, and runs word alignment. Alignment looks for runs of control tokens
// and asks the deserializer to slip one bit when no run is found in time.
module tmds_decoder #(
    parameter int unsigned LOCK_TOKENS    = 16,
    parameter int unsigned SEARCH_TIMEOUT = 8192,
    parameter int unsigned SLIP_WAIT      = 16
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic [9:0] sym_in,
    output logic       de,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic       bitslip
);

    localparam int unsigned TW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int unsigned SW = $clog2(SLIP_WAIT + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(SEARCH_TIMEOUT - 1);
    localparam logic [SW-1:0] SLIP_LAST  = SW'(SLIP_WAIT - 1);
    localparam logic [7:0]    RUN_FULL   = 8'(LOCK_TOKENS);
    localparam logic [7:0]    RUN_LAST   = 8'(LOCK_TOKENS - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    logic [9:0]    sym_q;
    logic [TW-1:0] timer;
    logic [SW-1:0] slip_cnt;
    logic [7:0]    run_cnt;

    logic          is_token;
    logic [1:0]    tok_ctrl;
    logic [7:0]    d_prime;
    logic [7:0]    dec;
    logic          run_hit;
    logic [7:0]    run_inc;

    // Stage 1: capture the incoming symbol.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            sym_q <= '0;
        end else begin
            sym_q <= sym_in;
        end
    end

    // Token recognition on the stage-1 symbol (exact match only).
    always_comb begin
        is_token = 1'b1;
        tok_ctrl = 2'b00;
        case (sym_q)
            10'b1101010100: tok_ctrl = 2'b00;
            10'b0010101011: tok_ctrl = 2'b01;
            10'b0101010100: tok_ctrl = 2'b10;
            10'b1010101011: tok_ctrl = 2'b11;
            default:        is_token = 1'b0;
        endcase
    end

    // Data decode: undo optional inversion, then undo XOR/XNOR chaining.
    always_comb begin
        d_prime = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
        dec     = '0;
        dec[0]  = d_prime[0];
        for (int unsigned i = 1; i < 8; i++) begin
            dec[i] = sym_q[8] ? (d_prime[i] ^ d_prime[i-1])
                              : ~(d_prime[i] ^ d_prime[i-1]);
        end
    end

    // Run bookkeeping: a hit is the run rising to its saturated length, so a
    // run that keeps going past LOCK_TOKENS produces only one hit.
    always_comb begin
        run_hit = is_token && (run_cnt == RUN_LAST);
        if (!is_token) begin
            run_inc = '0;
        end else if (run_cnt == RUN_FULL) begin
            run_inc = run_cnt;
        end else begin
            run_inc = run_cnt + 8'd1;
        end
    end

    // Stage 2: register decoded outputs; hold values when not applicable.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            de   <= 1'b0;
            data <= '0;
            ctrl <= '0;
        end else if (state == LOCKED) begin
            if (is_token) begin
                de   <= 1'b0;
                ctrl <= tok_ctrl;
            end else begin
                de   <= 1'b1;
                data <= dec;
            end
        end else begin
            de <= 1'b0;
        end
    end

    // Alignment FSM with registered locked/bitslip outputs.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state    <= SEARCH;
            timer    <= '0;
            slip_cnt <= '0;
            run_cnt  <= '0;
            locked   <= 1'b0;
            bitslip  <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            case (state)
                SEARCH: begin
                    run_cnt <= run_inc;
                    if (run_hit) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                        timer  <= '0;
                    end else if (timer == TIMER_LAST) begin
                        state    <= SLIP;
                        bitslip  <= 1'b1;
                        timer    <= '0;
                        slip_cnt <= '0;
                        run_cnt  <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SLIP: begin
                    run_cnt <= '0;
                    if (slip_cnt == SLIP_LAST) begin
                        state    <= SEARCH;
                        timer    <= '0;
                        slip_cnt <= '0;
                    end else begin
                        slip_cnt <= slip_cnt + SW'(1);
                    end
                end
                LOCKED: begin
                    run_cnt <= run_inc;
                    if (run_hit) begin
                        timer <= '0;
                    end else if (timer == TIMER_LAST) begin
                        state   <= SEARCH;
                        locked  <= 1'b0;
                        timer   <= '0;
                        run_cnt <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: scoreboarded decode checks plus
// cycle-exact checks of lock, watchdog, bitslip and reset behaviour.
module tb_tmds_decoder;

    logic       clk_pix = 1'b0;
    logic       rst_pix;
    logic [9:0] sym_in;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       locked;
    logic       bitslip;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    typedef struct {
        int unsigned due;
        logic        de;
        logic [7:0]  data;
        logic [1:0]  ctrl;
        logic        lk;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic       m_de;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;

    tmds_decoder #(
        .LOCK_TOKENS(16),
        .SEARCH_TIMEOUT(8192),
        .SLIP_WAIT(16)
    ) dut (
        .clk_pix(clk_pix),
        .rst_pix(rst_pix),
        .sym_in(sym_in),
        .de(de),
        .data(data),
        .ctrl(ctrl),
        .locked(locked),
        .bitslip(bitslip)
    );

    always #5 clk_pix = ~clk_pix;

    always @(posedge clk_pix) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference decode: {is_token, ctrl[1:0], data[7:0]}
    function automatic logic [10:0] ref_decode(input logic [9:0] q);
        logic [7:0] dp;
        logic [7:0] d;
        case (q)
            10'h354: return {1'b1, 2'b00, 8'h00};
            10'h0AB: return {1'b1, 2'b01, 8'h00};
            10'h154: return {1'b1, 2'b10, 8'h00};
            10'h2AB: return {1'b1, 2'b11, 8'h00};
            default: begin
                dp   = q[9] ? ~q[7:0] : q[7:0];
                d[0] = dp[0];
                for (int i = 1; i < 8; i++)
                    d[i] = q[8] ? (dp[i] ^ dp[i-1]) : ~(dp[i] ^ dp[i-1]);
                return {1'b0, 2'b00, d};
            end
        endcase
    endfunction

    // Drive one symbol; optionally push the expected stage-2 result.
    // 'applies' means the decoder is in LOCKED when this symbol is evaluated.
    task automatic drive(input logic [9:0] s, input bit push, input bit applies, input bit lk);
        logic [10:0] r;
        exp_t x;
        @(negedge clk_pix);
        sym_in = s;
        if (push) begin
            r = ref_decode(s);
            if (applies) begin
                if (r[10]) begin
                    m_de   = 1'b0;
                    m_ctrl = r[9:8];
                end else begin
                    m_de   = 1'b1;
                    m_data = r[7:0];
                end
            end else begin
                m_de = 1'b0;
            end
            x.due  = cyc + 2;
            x.de   = m_de;
            x.data = m_data;
            x.ctrl = m_ctrl;
            x.lk   = lk;
            sb.push_back(x);
        end
    endtask

    // Scoreboard: compare outputs when an expected entry falls due.
    always @(negedge clk_pix) begin
        if (!rst_pix && sb.size() > 0) begin
            if (sb[0].due < cyc) begin
                e = sb.pop_front();
                check("sb_late", cyc, e.due);
            end else if (sb[0].due == cyc) begin
                e = sb.pop_front();
                check("de", de, e.de);
                check("data", data, e.data);
                check("ctrl", ctrl, e.ctrl);
                check("locked", locked, e.lk);
                check("bitslip_sb", bitslip, 1'b0);
            end
        end
    end

    initial begin
        #2_000_000;
        n_cmp++;
        n_bad++;
        $display("FAIL global_timeout: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int unsigned d16;
        int unsigned r;
        int unsigned b;
        int unsigned drop_at;
        int unsigned bs_at;
        int unsigned bs_n;
        int unsigned lk_k;
        int unsigned bs_k;
        logic [9:0]  rs;
        logic [9:0]  tok4 [4];

        rst_pix = 1'b1;
        sym_in  = '0;
        m_de    = 1'b0;
        m_data  = '0;
        m_ctrl  = '0;
        d16     = 0;

        // Reset state
        repeat (3) @(negedge clk_pix);
        check("rst_de", de, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_ctrl", ctrl, 2'b00);
        check("rst_locked", locked, 1'b0);
        check("rst_bitslip", bitslip, 1'b0);
        @(negedge clk_pix);
        rst_pix = 1'b0;

        // Lock acquisition: 20 tokens then a data symbol
        for (int i = 1; i <= 20; i++)
            drive(10'h354, 1'b1, (i >= 17), (i >= 16));
        drive(10'h100, 1'b1, 1'b1, 1'b1);

        // Data decode patterns
        drive(10'h3FF, 1'b1, 1'b1, 1'b1);
        drive(10'h200, 1'b1, 1'b1, 1'b1);
        drive(10'h100, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            rs = 10'($urandom_range(0, 1023));
            if (ref_decode(rs) >= 11'h400) rs = 10'h1A5;
            drive(rs, 1'b1, 1'b1, 1'b1);
        end

        // All four control tokens, data holds
        tok4[0] = 10'h354;
        tok4[1] = 10'h0AB;
        tok4[2] = 10'h154;
        tok4[3] = 10'h2AB;
        for (int i = 0; i < 4; i++)
            drive(tok4[i], 1'b1, 1'b1, 1'b1);
        drive(10'h100, 1'b1, 1'b1, 1'b1);
        drive(10'h100, 1'b1, 1'b1, 1'b1);

        // Long run of 40 tokens: only the 16th clears the watchdog
        for (int i = 1; i <= 40; i++) begin
            drive(10'h354, 1'b1, 1'b1, 1'b1);
            if (i == 16) d16 = cyc;
        end

        // Watchdog expiry then search timeout
        drop_at = 0;
        bs_at   = 0;
        bs_n    = 0;
        while ((cyc - d16) < 16400) begin
            @(negedge clk_pix);
            sym_in = 10'h100;
            if (!locked && drop_at == 0) drop_at = cyc - d16;
            if (bitslip) begin
                bs_n++;
                if (bs_at == 0) bs_at = cyc - d16;
            end
        end
        check("wd_drop_cycle", drop_at, 8194);
        check("wd_bitslip_cycle", bs_at, 16386);
        check("wd_bitslip_count", bs_n, 1);

        // Reset, data-only symbols: one bitslip after the search timeout
        @(negedge clk_pix);
        rst_pix = 1'b1;
        sb.delete();
        m_data = '0;
        m_ctrl = '0;
        repeat (2) @(negedge clk_pix);
        rst_pix = 1'b0;
        sym_in  = 10'h100;
        r       = cyc;
        bs_k    = 0;
        for (int k = 1; k <= 8300; k++) begin
            @(negedge clk_pix);
            if (bitslip) begin
                bs_k = k;
                break;
            end
        end
        check("search_bitslip_cycle", bs_k, 8192);
        check("search_locked", locked, 1'b0);

        // Tokens during SLIP are ignored; lock needs 16 tokens after SLIP
        b      = cyc;
        sym_in = 10'h354;
        bs_n   = 0;
        lk_k   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_pix);
            if (bitslip) bs_n++;
            if (locked && lk_k == 0) lk_k = cyc - b;
        end
        check("slip_no_repulse", bs_n, 0);
        check("slip_lock_cycle", lk_k, 32);

        // Asynchronous reset while locked
        @(negedge clk_pix);
        #3 rst_pix = 1'b1;
        #1;
        check("arst_de", de, 1'b0);
        check("arst_data", data, 8'h00);
        check("arst_ctrl", ctrl, 2'b00);
        check("arst_locked", locked, 1'b0);
        check("arst_bitslip", bitslip, 1'b0);
        repeat (2) @(negedge clk_pix);
        rst_pix = 1'b0;
        sym_in  = 10'h100;
        r       = cyc;

        // Fresh 16-token run timed to coincide with the search timeout
        bs_n = 0;
        lk_k = 0;
        for (int k = 1; k <= 8210; k++) begin
            @(negedge clk_pix);
            if (bitslip) bs_n++;
            if (locked && lk_k == 0) lk_k = k;
            sym_in = (k >= 8175 && k <= 8190) ? 10'h354 : 10'h100;
        end
        check("tie_lock_cycle", lk_k, 8192);
        check("tie_no_bitslip", bs_n, 0);
        check("tie_locked_end", locked, 1'b1);

        repeat (4) @(negedge clk_pix);
        check("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
